// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: computes a - b one bit per clock, LSB first, and
// presents diff plus borrow/overflow/zero flags together with a one-cycle done pulse.
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             ovf,
    output logic             zero
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_t;

    state_t           state_r;
    state_t           state_s;
    logic [WIDTH-1:0] a_sh_r;
    logic [WIDTH-1:0] b_sh_r;
    logic [WIDTH-1:0] res_r;
    logic [CW-1:0]    cnt_r;
    logic             br_r;
    logic             a_msb_r;
    logic             b_msb_r;
    logic [1:0]       fs_s;
    logic [WIDTH-1:0] res_next_s;
    logic             last_s;

    // One-bit full subtractor: returns {borrow_out, difference}.
    function automatic logic [1:0] full_sub(input logic ai, input logic bi, input logic bri);
        logic d;
        logic brn;
        d   = ai ^ bi ^ bri;
        brn = (~ai & bi) | (~(ai ^ bi) & bri);
        return {brn, d};
    endfunction

    // Current-bit arithmetic and the result word as it will look after this bit.
    always_comb begin
        fs_s       = full_sub(a_sh_r[0], b_sh_r[0], br_r);
        res_next_s = {fs_s[0], res_r[WIDTH-1:1]};
        last_s     = (cnt_r == LAST);
    end

    // Next-state logic for the IDLE -> RUN -> DONE sequence.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (start) begin
                    state_s = RUN;
                end else begin
                    state_s = IDLE;
                end
            end
            RUN: begin
                if (last_s) begin
                    state_s = DONE;
                end else begin
                    state_s = RUN;
                end
            end
            DONE:    state_s = IDLE;
            default: state_s = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Datapath, status and result registers; results change only on the final RUN edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a_sh_r  <= {WIDTH{1'b0}};
            b_sh_r  <= {WIDTH{1'b0}};
            res_r   <= {WIDTH{1'b0}};
            cnt_r   <= {CW{1'b0}};
            br_r    <= 1'b0;
            a_msb_r <= 1'b0;
            b_msb_r <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            diff    <= {WIDTH{1'b0}};
            bout    <= 1'b0;
            ovf     <= 1'b0;
            zero    <= 1'b0;
        end else begin
            busy <= (state_s != IDLE);
            done <= (state_r == RUN) && last_s;
            case (state_r)
                IDLE: begin
                    if (start) begin
                        a_sh_r  <= a;
                        b_sh_r  <= b;
                        a_msb_r <= a[WIDTH-1];
                        b_msb_r <= b[WIDTH-1];
                        res_r   <= {WIDTH{1'b0}};
                        cnt_r   <= {CW{1'b0}};
                        br_r    <= 1'b0;
                    end
                end
                RUN: begin
                    a_sh_r <= {1'b0, a_sh_r[WIDTH-1:1]};
                    b_sh_r <= {1'b0, b_sh_r[WIDTH-1:1]};
                    res_r  <= res_next_s;
                    br_r   <= fs_s[1];
                    cnt_r  <= cnt_r + CW'(1);
                    if (last_s) begin
                        // Overflow: operand signs differ and the result sign differs from a.
                        diff <= res_next_s;
                        bout <= fs_s[1];
                        ovf  <= (a_msb_r ^ b_msb_r) & (fs_s[0] ^ a_msb_r);
                        zero <= (res_next_s == {WIDTH{1'b0}});
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_subtractor.sv
// Randomized scoreboard bench for serial_subtractor: a driver pushes expected
// results from an arithmetic model, a monitor pops and compares on every done.
module tb_serial_subtractor;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] diff;
    logic         bout;
    logic         ovf;
    logic         zero;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int done_cnt = 0;
    int last_done_cyc = 0;
    int prev_done_cyc = 0;
    logic [W-1:0] last_diff = '0;
    logic [W+2:0] exp_q[$];

    serial_subtractor #(.WIDTH(W)) dut (
        .clk(clk), .reset(reset), .start(start), .a(a), .b(b),
        .busy(busy), .done(done), .diff(diff), .bout(bout), .ovf(ovf), .zero(zero)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    // Reference: plain integer arithmetic, result packed as {diff, bout, ovf, zero}.
    function automatic logic [W+2:0] model(input logic [W-1:0] x, input logic [W-1:0] y);
        int ud;
        int sd;
        logic [W-1:0] d;
        logic br;
        logic ov;
        ud = int'(x) - int'(y);
        d  = ud[W-1:0];
        br = (ud < 0);
        sd = int'($signed(x)) - int'($signed(y));
        ov = (sd > (2 ** (W - 1)) - 1) || (sd < -(2 ** (W - 1)));
        return {d, br, ov, (d == '0)};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: every done pulse consumes one scoreboard entry.
    always @(negedge clk) begin
        logic [W+2:0] e;
        if (!reset && done) begin
            done_cnt++;
            prev_done_cyc = last_done_cyc;
            last_done_cyc = cyc;
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_done: got done=1 expected no pending result (t=%0t)", $time);
            end else begin
                e = exp_q.pop_front();
                chk("result", {diff, bout, ovf, zero}, e);
                last_diff = e[W+2:3];
            end
        end
    end

    task automatic wait_idle();
        int g = 0;
        @(negedge clk);
        while (busy && g < 100) begin
            @(negedge clk);
            g++;
        end
        chk("idle_timeout", busy, 1'b0);
    endtask

    // Issue one operation and check latency, diff holding, and busy/done shape.
    task automatic do_op(input logic [W-1:0] x, input logic [W-1:0] y);
        logic [W-1:0] pd;
        int k;
        logic seen;
        wait_idle();
        a = x;
        b = y;
        start = 1'b1;
        exp_q.push_back(model(x, y));
        pd = last_diff;
        @(posedge clk);
        #1;
        start = 1'b0;
        a = W'($urandom);
        b = W'($urandom);
        k = -1;
        seen = 1'b0;
        while (!seen && k < 50) begin
            @(negedge clk);
            k++;
            if (done) begin
                seen = 1'b1;
            end else begin
                chk("diff_hold", diff, pd);
                chk("busy_run", busy, 1'b1);
            end
        end
        chk("latency", k, W);
        @(negedge clk);
        chk("done_one_cycle", done, 1'b0);
        chk("busy_fall", busy, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0;
        int acc;
        int g;
        reset = 1'b1;
        start = 1'b0;
        a = '0;
        b = '0;
        repeat (2) @(negedge clk);
        chk("reset_outs", {busy, done, diff, bout, ovf, zero}, '0);
        reset = 1'b0;

        // Directed corner cases.
        do_op(8'h05, 8'h03);
        do_op(8'h03, 8'h05);
        do_op(8'h80, 8'h01);
        do_op(8'h7F, 8'hFF);
        do_op(8'h5A, 8'h5A);

        // Start re-pulsed mid-RUN with new operands must be ignored.
        wait_idle();
        d0 = done_cnt;
        a = 8'h12;
        b = 8'h34;
        start = 1'b1;
        exp_q.push_back(model(8'h12, 8'h34));
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        start = 1'b1;
        a = 8'hFF;
        b = 8'h00;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_idle();
        repeat (W + 4) @(negedge clk);
        chk("restart_done_count", done_cnt - d0, 1);
        chk("restart_queue_empty", exp_q.size(), 0);

        // Reset during RUN aborts with all outputs cleared and no done.
        wait_idle();
        a = 8'h33;
        b = 8'h11;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        chk("reset_abort_outs", {busy, done, diff, bout, ovf, zero}, '0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        last_diff = '0;
        d0 = done_cnt;
        repeat (W + 4) @(negedge clk);
        chk("abort_no_done", done_cnt - d0, 0);
        do_op(8'h10, 8'h01);

        // Start held high: back-to-back operations every W+2 cycles.
        wait_idle();
        a = 8'hC3;
        b = 8'h3C;
        start = 1'b1;
        acc = 0;
        g = 0;
        while (acc < 2 && g < 100) begin
            if (!busy) begin
                exp_q.push_back(model(8'hC3, 8'h3C));
                acc++;
                if (acc == 2) begin
                    @(posedge clk);
                    #1;
                    start = 1'b0;
                end
            end
            if (acc < 2) @(negedge clk);
            g++;
        end
        chk("b2b_accepts", acc, 2);
        wait_idle();
        repeat (2) @(negedge clk);
        chk("b2b_interval", last_done_cyc - prev_done_cyc, W + 2);

        // Randomized operations with random idle gaps.
        for (int i = 0; i < 40; i++) begin
            do_op(W'($urandom), W'($urandom));
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        repeat (4) @(negedge clk);
        chk("final_queue_empty", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
